// File: rtl/tracker_pkg.sv
// Shared definitions for the APB column tracker: FSM encoding, default
// board geometry and polling constants, and small arithmetic helpers.
package tracker_pkg;

    // State encodings shared by the tracker FSM
    localparam logic [1:0] ENC_IDLE   = 2'd0;
    localparam logic [1:0] ENC_WAIT   = 2'd1;
    localparam logic [1:0] ENC_SETUP  = 2'd2;
    localparam logic [1:0] ENC_ACCESS = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = ENC_IDLE,
        ST_WAIT   = ENC_WAIT,
        ST_SETUP  = ENC_SETUP,
        ST_ACCESS = ENC_ACCESS
    } state_e;

    // Full carriage travel in steps; the column pitch is derived from it
    localparam logic [31:0] MAX_TRAVEL_STEPS  = 32'd4900;
    localparam int unsigned DEF_NUM_COLS      = 7;
    localparam logic [31:0] DEF_COL_PITCH     = MAX_TRAVEL_STEPS / 32'(DEF_NUM_COLS);
    localparam logic [31:0] DEF_COL_OFFSET    = 32'd350;
    localparam logic [31:0] DEF_TOLERANCE     = 32'd10;
    localparam logic [31:0] DEF_POLL_INTERVAL = 32'd50000;
    localparam logic [31:0] DEF_POS_ADDR      = 32'h0000_0000;
    localparam logic [15:0] DEF_TIMEOUT       = 16'd255;

    // Step position of the centre of a given column
    function automatic logic [31:0] colTarget(input logic [2:0]  col,
                                              input logic [31:0] offset,
                                              input logic [31:0] pitch);
        return offset + ({29'd0, col} * pitch);
    endfunction

    // Unsigned distance, larger operand first so nothing wraps
    function automatic logic [31:0] absDiff(input logic [31:0] a,
                                            input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/apb_read_master.sv
// Single-read APB requester: runs one SETUP/ACCESS read per start pulse,
// aborts after TIMEOUT access cycles, and strobes ok/fail as it finishes.
module apb_read_master #(
    parameter logic [31:0] ADDR    = 32'h0000_0000,
    parameter logic [15:0] TIMEOUT = 16'd255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_pready,
    input  logic        i_pslverr,
    input  logic [31:0] i_prdata,
    output logic        o_psel,
    output logic        o_penable,
    output logic [31:0] o_paddr,
    output logic        o_done,
    output logic        o_ok,
    output logic        o_fail,
    output logic [31:0] o_rdata
);

    logic        r_psel;
    logic        r_penable;
    logic [31:0] r_paddr;
    logic [15:0] r_waitCnt;

    logic w_setup;
    logic w_access;
    logic w_timeout;

    assign w_setup   = r_psel & ~r_penable;
    assign w_access  = r_psel &  r_penable;
    assign w_timeout = w_access & ~i_pready & (r_waitCnt >= TIMEOUT);

    assign o_ok    = w_access & i_pready & ~i_pslverr;
    assign o_fail  = w_access & ((i_pready & i_pslverr) | w_timeout);
    assign o_done  = o_ok | o_fail;
    assign o_rdata = i_prdata;

    assign o_psel    = r_psel;
    assign o_penable = r_penable;
    assign o_paddr   = r_paddr;

    // Bus phase sequencing and access-cycle counting (count is 1 in the first ACCESS cycle)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_paddr   <= 32'd0;
            r_waitCnt <= 16'd0;
        end else if (i_start) begin
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_paddr   <= ADDR;
            r_waitCnt <= 16'd0;
        end else if (w_setup) begin
            r_penable <= 1'b1;
            r_waitCnt <= 16'd1;
        end else if (w_access) begin
            if (o_done) begin
                r_psel    <= 1'b0;
                r_penable <= 1'b0;
                r_waitCnt <= 16'd0;
            end else begin
                r_waitCnt <= r_waitCnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/apb_column_tracker.sv
// Polls the stepper carriage position over APB and reports whether the
// carriage is within tolerance of the most recently requested column.
module apb_column_tracker
    import tracker_pkg::*;
#(
    parameter logic [31:0] POLL_INTERVAL = DEF_POLL_INTERVAL,
    parameter logic [31:0] POS_ADDR      = DEF_POS_ADDR,
    parameter logic [31:0] COL_OFFSET    = DEF_COL_OFFSET,
    parameter logic [31:0] COL_PITCH     = DEF_COL_PITCH,
    parameter int unsigned NUM_COLS      = DEF_NUM_COLS,
    parameter logic [31:0] TOLERANCE     = DEF_TOLERANCE,
    parameter logic [15:0] TIMEOUT       = DEF_TIMEOUT
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd_col,
    output logic        cmd_ready,
    output logic        at_target,
    output logic [31:0] cur_pos,
    output logic        pos_valid,
    output logic        err,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    input  logic [31:0] PRDATA
);

    state_e      r_state;
    state_e      w_nextState;
    logic [31:0] r_intervalCnt;
    logic [31:0] r_target;
    logic [31:0] r_curPos;
    logic        r_atTarget;
    logic        r_posValid;
    logic        r_err;
    logic        r_cmdReady;

    logic        w_cmdFire;
    logic        w_colValid;
    logic        w_cmdLoad;
    logic        w_cmdBad;
    logic        w_start;
    logic        w_rdDone;
    logic        w_rdOk;
    logic        w_rdFail;
    logic [31:0] w_rdData;
    logic [31:0] w_newTarget;
    logic [31:0] w_dist;

    assign w_cmdFire   = cmd_valid & r_cmdReady;
    assign w_colValid  = ({29'd0, cmd_col} < NUM_COLS);
    assign w_cmdLoad   = w_cmdFire &  w_colValid;
    assign w_cmdBad    = w_cmdFire & ~w_colValid;
    assign w_newTarget = colTarget(cmd_col, COL_OFFSET, COL_PITCH);
    assign w_dist      = absDiff(w_rdData, r_target);
    assign w_start     = ((r_state == ST_IDLE) || (r_state == ST_WAIT)) &&
                         (w_nextState == ST_SETUP);

    apb_read_master #(
        .ADDR    (POS_ADDR),
        .TIMEOUT (TIMEOUT)
    ) u_reader (
        .i_clk     (PCLK),
        .i_rst_n   (PRESERN),
        .i_start   (w_start),
        .i_pready  (PREADY),
        .i_pslverr (PSLVERR),
        .i_prdata  (PRDATA),
        .o_psel    (PSEL),
        .o_penable (PENABLE),
        .o_paddr   (PADDR),
        .o_done    (w_rdDone),
        .o_ok      (w_rdOk),
        .o_fail    (w_rdFail),
        .o_rdata   (w_rdData)
    );

    // State register
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: a new valid target always restarts polling right away
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cmdLoad) begin
                    w_nextState = ST_SETUP;
                end
            end
            ST_WAIT: begin
                if (w_cmdLoad || (r_intervalCnt == POLL_INTERVAL)) begin
                    w_nextState = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_nextState = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (w_rdDone) begin
                    w_nextState = ST_WAIT;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Interval counter runs 1..POLL_INTERVAL while waiting between reads
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_intervalCnt <= 32'd0;
        end else if (w_nextState == ST_WAIT) begin
            r_intervalCnt <= (r_state == ST_WAIT) ? (r_intervalCnt + 32'd1) : 32'd1;
        end else begin
            r_intervalCnt <= 32'd0;
        end
    end

    // Target column position, only changed by an accepted valid command
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_target <= 32'd0;
        end else if (w_cmdLoad) begin
            r_target <= w_newTarget;
        end
    end

    // Read results, error pulses and on-target flag; a new target wins over a finishing read
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_curPos   <= 32'd0;
            r_posValid <= 1'b0;
            r_err      <= 1'b0;
            r_atTarget <= 1'b0;
        end else begin
            r_posValid <= w_rdOk;
            r_err      <= w_rdFail | w_cmdBad;
            if (w_rdOk) begin
                r_curPos <= w_rdData;
            end
            if (w_cmdLoad) begin
                r_atTarget <= 1'b0;
            end else if (w_rdOk) begin
                r_atTarget <= (w_dist <= TOLERANCE);
            end
        end
    end

    // Commands are refused only while a read is in its ACCESS phase
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_cmdReady <= 1'b1;
        end else begin
            r_cmdReady <= (w_nextState != ST_ACCESS);
        end
    end

    assign cmd_ready = r_cmdReady;
    assign at_target = r_atTarget;
    assign cur_pos   = r_curPos;
    assign pos_valid = r_posValid;
    assign err       = r_err;
    assign PWRITE    = 1'b0;
    assign PWDATA    = 32'd0;

endmodule

// File: tb/tb_apb_column_tracker.sv
// Directed bench for apb_column_tracker with a short poll interval and a
// non-zero position address so address and timing are observable.
module tb_apb_column_tracker;

    localparam int POLL = 20;

    logic        PCLK;
    logic        PRESERN;
    logic        cmd_valid;
    logic [2:0]  cmd_col;
    logic        cmd_ready;
    logic        at_target;
    logic [31:0] cur_pos;
    logic        pos_valid;
    logic        err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] PRDATA;

    int checks   = 0;
    int failures = 0;

    apb_column_tracker #(
        .POLL_INTERVAL (32'd20),
        .POS_ADDR      (32'h0000_0040)
    ) dut (
        .PCLK      (PCLK),
        .PRESERN   (PRESERN),
        .cmd_valid (cmd_valid),
        .cmd_col   (cmd_col),
        .cmd_ready (cmd_ready),
        .at_target (at_target),
        .cur_pos   (cur_pos),
        .pos_valid (pos_valid),
        .err       (err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .PRDATA    (PRDATA)
    );

    // Free-running 10 ns clock
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Step until a SETUP phase appears, reporting how many edges it took
    task automatic waitSetup(input int budget, output int n, output bit found);
        n = 0;
        found = 1'b0;
        while (n < budget && !found) begin
            tick();
            n++;
            if (PSEL && !PENABLE) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        PRESERN = 1'b0;
        repeat (3) tick();
        checks++; if (PSEL !== 1'b0) begin failures++; $display("[TB] FAIL rst_psel got=%0b want=0", PSEL); end
        checks++; if (PENABLE !== 1'b0) begin failures++; $display("[TB] FAIL rst_penable got=%0b want=0", PENABLE); end
        checks++; if (PWRITE !== 1'b0) begin failures++; $display("[TB] FAIL rst_pwrite got=%0b want=0", PWRITE); end
        checks++; if (PADDR !== 32'd0) begin failures++; $display("[TB] FAIL rst_paddr got=%0h want=0", PADDR); end
        checks++; if (PWDATA !== 32'd0) begin failures++; $display("[TB] FAIL rst_pwdata got=%0h want=0", PWDATA); end
        checks++; if (at_target !== 1'b0) begin failures++; $display("[TB] FAIL rst_at_target got=%0b want=0", at_target); end
        checks++; if (cur_pos !== 32'd0) begin failures++; $display("[TB] FAIL rst_cur_pos got=%0d want=0", cur_pos); end
        checks++; if (pos_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_pos_valid got=%0b want=0", pos_valid); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL rst_err got=%0b want=0", err); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_cmd_ready got=%0b want=1", cmd_ready); end
        PRESERN = 1'b1;
        repeat (3) tick();
        checks++; if (PSEL !== 1'b0) begin failures++; $display("[TB] FAIL idle_no_poll got=%0b want=0", PSEL); end
    endtask

    task automatic test_zero_wait();
        PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'd2450;
        cmd_valid = 1'b1; cmd_col = 3'd3;
        tick();
        cmd_valid = 1'b0;
        checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0) begin failures++; $display("[TB] FAIL zw_setup got=%0b%0b want=10", PSEL, PENABLE); end
        checks++; if (PADDR !== 32'h40) begin failures++; $display("[TB] FAIL zw_paddr got=%0h want=40", PADDR); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL zw_ready_setup got=%0b want=1", cmd_ready); end
        tick();
        checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin failures++; $display("[TB] FAIL zw_access got=%0b%0b want=11", PSEL, PENABLE); end
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL zw_ready_access got=%0b want=0", cmd_ready); end
        checks++; if (PWRITE !== 1'b0) begin failures++; $display("[TB] FAIL zw_pwrite got=%0b want=0", PWRITE); end
        tick();
        checks++; if (PSEL !== 1'b0) begin failures++; $display("[TB] FAIL zw_drop got=%0b want=0", PSEL); end
        checks++; if (pos_valid !== 1'b1) begin failures++; $display("[TB] FAIL zw_pos_valid got=%0b want=1", pos_valid); end
        checks++; if (cur_pos !== 32'd2450) begin failures++; $display("[TB] FAIL zw_cur_pos got=%0d want=2450", cur_pos); end
        checks++; if (at_target !== 1'b1) begin failures++; $display("[TB] FAIL zw_at_target got=%0b want=1", at_target); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL zw_err got=%0b want=0", err); end
        tick();
        checks++; if (pos_valid !== 1'b0) begin failures++; $display("[TB] FAIL zw_pulse got=%0b want=0", pos_valid); end
    endtask

    task automatic test_tolerance();
        int n;
        bit found;
        PRDATA = 32'd2465;
        waitSetup(40, n, found);
        checks++; if (!found) begin failures++; $display("[TB] FAIL tol_setup1 got=none want=setup"); end
        tick(); tick();
        checks++; if (at_target !== 1'b0) begin failures++; $display("[TB] FAIL tol_off15 got=%0b want=0", at_target); end
        checks++; if (cur_pos !== 32'd2465) begin failures++; $display("[TB] FAIL tol_pos1 got=%0d want=2465", cur_pos); end
        PRDATA = 32'd2460;
        waitSetup(40, n, found);
        checks++; if (!found) begin failures++; $display("[TB] FAIL tol_setup2 got=none want=setup"); end
        tick(); tick();
        checks++; if (at_target !== 1'b1) begin failures++; $display("[TB] FAIL tol_on10 got=%0b want=1", at_target); end
        checks++; if (cur_pos !== 32'd2460) begin failures++; $display("[TB] FAIL tol_pos2 got=%0d want=2460", cur_pos); end
    endtask

    task automatic test_wait_states();
        int cnt;
        cnt = 0;
        PREADY = 1'b0; PRDATA = 32'd350;
        cmd_valid = 1'b1; cmd_col = 3'd0;
        tick();
        cmd_valid = 1'b0;
        checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0) begin failures++; $display("[TB] FAIL ws_setup got=%0b%0b want=10", PSEL, PENABLE); end
        checks++; if (at_target !== 1'b0) begin failures++; $display("[TB] FAIL ws_clear got=%0b want=0", at_target); end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!PSEL) break;
            if (PENABLE) cnt++;
            if (cnt == 4) PREADY = 1'b1;
        end
        checks++; if (cnt != 4) begin failures++; $display("[TB] FAIL ws_penable_cycles got=%0d want=4", cnt); end
        checks++; if (PSEL !== 1'b0) begin failures++; $display("[TB] FAIL ws_drop got=%0b want=0", PSEL); end
        checks++; if (pos_valid !== 1'b1) begin failures++; $display("[TB] FAIL ws_pos_valid got=%0b want=1", pos_valid); end
        checks++; if (at_target !== 1'b1) begin failures++; $display("[TB] FAIL ws_at_target got=%0b want=1", at_target); end
        checks++; if (cur_pos !== 32'd350) begin failures++; $display("[TB] FAIL ws_cur_pos got=%0d want=350", cur_pos); end
    endtask

    task automatic test_timeout();
        int n;
        bit found;
        int cnt;
        int errSeen;
        int pvSeen;
        bit dropped;
        cnt = 0; errSeen = 0; pvSeen = 0; dropped = 1'b0;
        PREADY = 1'b0;
        waitSetup(40, n, found);
        checks++; if (!found || n != POLL) begin failures++; $display("[TB] FAIL to_interval got=%0d want=%0d", n, POLL); end
        for (int i = 0; i < 300; i++) begin
            tick();
            if (err) errSeen++;
            if (pos_valid) pvSeen++;
            if (!PSEL) begin dropped = 1'b1; break; end
            if (PENABLE) cnt++;
        end
        checks++; if (!dropped) begin failures++; $display("[TB] FAIL to_drop got=held want=dropped"); end
        checks++; if (cnt != 255) begin failures++; $display("[TB] FAIL to_access_cycles got=%0d want=255", cnt); end
        tick();
        if (err) errSeen++;
        checks++; if (errSeen != 1) begin failures++; $display("[TB] FAIL to_err_pulses got=%0d want=1", errSeen); end
        checks++; if (pvSeen != 0) begin failures++; $display("[TB] FAIL to_pos_valid got=%0d want=0", pvSeen); end
        checks++; if (cur_pos !== 32'd350) begin failures++; $display("[TB] FAIL to_cur_pos got=%0d want=350", cur_pos); end
        checks++; if (at_target !== 1'b1) begin failures++; $display("[TB] FAIL to_at_target got=%0b want=1", at_target); end
        // One edge already elapsed since the drop
        waitSetup(40, n, found);
        checks++; if (!found || n != POLL - 1) begin failures++; $display("[TB] FAIL to_next_setup got=%0d want=%0d", n, POLL - 1); end
    endtask

    task automatic test_slverr();
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'd0;
        tick(); tick();
        PSLVERR = 1'b0;
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL se_err got=%0b want=1", err); end
        checks++; if (pos_valid !== 1'b0) begin failures++; $display("[TB] FAIL se_pos_valid got=%0b want=0", pos_valid); end
        checks++; if (cur_pos !== 32'd350) begin failures++; $display("[TB] FAIL se_cur_pos got=%0d want=350", cur_pos); end
        checks++; if (at_target !== 1'b1) begin failures++; $display("[TB] FAIL se_at_target got=%0b want=1", at_target); end
        checks++; if (PSEL !== 1'b0) begin failures++; $display("[TB] FAIL se_drop got=%0b want=0", PSEL); end
    endtask

    task automatic test_bad_col();
        int n;
        bit found;
        cmd_valid = 1'b1; cmd_col = 3'd7;
        tick();
        cmd_valid = 1'b0;
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL bc_err got=%0b want=1", err); end
        checks++; if (PSEL !== 1'b0) begin failures++; $display("[TB] FAIL bc_no_setup got=%0b want=0", PSEL); end
        checks++; if (at_target !== 1'b1) begin failures++; $display("[TB] FAIL bc_at_target got=%0b want=1", at_target); end
        tick();
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL bc_err_pulse got=%0b want=0", err); end
        PRDATA = 32'd350;
        waitSetup(40, n, found);
        checks++; if (!found) begin failures++; $display("[TB] FAIL bc_setup got=none want=setup"); end
        tick(); tick();
        checks++; if (at_target !== 1'b1) begin failures++; $display("[TB] FAIL bc_target_kept got=%0b want=1", at_target); end
    endtask

    task automatic test_wait_cmd();
        int n;
        bit found;
        PRDATA = 32'd4560;
        cmd_valid = 1'b1; cmd_col = 3'd6;
        tick();
        cmd_valid = 1'b0;
        checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0) begin failures++; $display("[TB] FAIL wc_setup got=%0b%0b want=10", PSEL, PENABLE); end
        checks++; if (at_target !== 1'b0) begin failures++; $display("[TB] FAIL wc_clear got=%0b want=0", at_target); end
        tick(); tick();
        checks++; if (at_target !== 1'b1) begin failures++; $display("[TB] FAIL wc_above10 got=%0b want=1", at_target); end
        checks++; if (cur_pos !== 32'd4560) begin failures++; $display("[TB] FAIL wc_cur_pos got=%0d want=4560", cur_pos); end
        PRDATA = 32'd4561;
        waitSetup(40, n, found);
        checks++; if (!found) begin failures++; $display("[TB] FAIL wc_setup2 got=none want=setup"); end
        tick(); tick();
        checks++; if (at_target !== 1'b0) begin failures++; $display("[TB] FAIL wc_above11 got=%0b want=0", at_target); end
    endtask

    task automatic test_below_and_wrap();
        int n;
        bit found;
        PRDATA = 32'd340;
        cmd_valid = 1'b1; cmd_col = 3'd0;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        checks++; if (at_target !== 1'b1) begin failures++; $display("[TB] FAIL bw_below10 got=%0b want=1", at_target); end
        PRDATA = 32'hFFFF_FFFF;
        waitSetup(40, n, found);
        checks++; if (!found) begin failures++; $display("[TB] FAIL bw_setup got=none want=setup"); end
        tick(); tick();
        checks++; if (at_target !== 1'b0) begin failures++; $display("[TB] FAIL bw_no_wrap got=%0b want=0", at_target); end
        checks++; if (cur_pos !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL bw_cur_pos got=%0h want=ffffffff", cur_pos); end
    endtask

    task automatic test_reset_mid();
        int n;
        bit found;
        int pselSeen;
        pselSeen = 0;
        PREADY = 1'b0;
        waitSetup(40, n, found);
        tick();
        checks++; if (!found || PENABLE !== 1'b1) begin failures++; $display("[TB] FAIL rm_access got=%0b want=1", PENABLE); end
        #2;
        PRESERN = 1'b0;
        #1;
        checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin failures++; $display("[TB] FAIL rm_async_drop got=%0b%0b want=00", PSEL, PENABLE); end
        checks++; if (cur_pos !== 32'd0) begin failures++; $display("[TB] FAIL rm_cur_pos got=%0h want=0", cur_pos); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL rm_cmd_ready got=%0b want=1", cmd_ready); end
        @(negedge PCLK);
        PRESERN = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (PSEL) pselSeen++;
        end
        checks++; if (pselSeen != 0) begin failures++; $display("[TB] FAIL rm_target_lost got=%0d want=0", pselSeen); end
        cmd_valid = 1'b1; cmd_col = 3'd7;
        tick();
        cmd_valid = 1'b0;
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL rm_idle_bad_err got=%0b want=1", err); end
        tick();
        checks++; if (PSEL !== 1'b0) begin failures++; $display("[TB] FAIL rm_idle_stay got=%0b want=0", PSEL); end
    endtask

    // Scenario sequence; each task picks up where the previous one left the DUT
    initial begin
        PRESERN   = 1'b0;
        cmd_valid = 1'b0;
        cmd_col   = 3'd0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        PRDATA    = 32'd0;
        test_reset();
        test_zero_wait();
        test_tolerance();
        test_wait_states();
        test_timeout();
        test_slverr();
        test_bad_col();
        test_wait_cmd();
        test_below_and_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
